// File: rtl/imem_responder_if.sv
// Cache-refill request/response bus between the I-cache miss path (master)
// and the memory-side responder (slave).
interface imem_responder_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/imem_responder.sv
// Memory-side responder for I-cache refills: fixed-latency single-word reads
// from a program-loaded word array, with a small FIFO for requests that
// arrive while a read is in flight and sticky overflow/range error flags.
module imem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_responder_if.slave       bus,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_range
);

  localparam int          DEPTH  = 1 << ADDR_WIDTH;
  localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          FCW    = $clog2(QDEPTH + 1);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic                  oor;
    logic [ADDR_WIDTH-1:0] idx;
  } req_t;

  logic [31:0] mem [0:DEPTH-1];
  req_t        fifo_q [0:QDEPTH-1];

  state_t         state_q, state_d;
  logic [3:0]     cd_q, cd_d;
  req_t           cur_q, cur_d;
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic [31:0]    rdata_q;
  logic           err_ov_q, err_ov_d, err_rg_q, err_rg_d;

  req_t in_req;
  logic push, pop, drop, fifo_full, fifo_empty, load_resp;
  logic unused_addr_lsbs;

  // Byte address -> word index; any set bit above the array is out of range.
  assign in_req.idx       = bus.mem_req_addr[ADDR_WIDTH+1:2];
  assign in_req.oor       = |bus.mem_req_addr[31:ADDR_WIDTH+2];
  assign unused_addr_lsbs = ^bus.mem_req_addr[1:0];

  assign fifo_full  = (cnt_q == FCW'(QDEPTH));
  assign fifo_empty = (cnt_q == '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state: start, countdown, queue or drop requests; response when countdown hits 0.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cur_d   = cur_q;
    push    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_valid) begin
          state_d = BUSY;
          cd_d    = LAT_M1;
          cur_d   = in_req;
        end
      end
      BUSY: begin
        if (cd_q != 4'd0) begin
          cd_d = cd_q - 4'd1;
          if (bus.mem_req_valid) begin
            drop = fifo_full;
            push = ~fifo_full;
          end
        end else if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = fifo_q[rd_q];
          cd_d  = LAT_M1;
          push  = bus.mem_req_valid;
        end else if (bus.mem_req_valid) begin
          cur_d = in_req;
          cd_d  = LAT_M1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/occupancy and sticky error next-state (set beats clear).
  always_comb begin
    rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + FCW'(1);
      2'b01:   cnt_d = cnt_q - FCW'(1);
      default: cnt_d = cnt_q;
    endcase
    err_ov_d = (err_ov_q & ~err_clear) | drop;
    err_rg_d = (err_rg_q & ~err_clear) | (bus.mem_req_valid & ~drop & in_req.oor);
  end

  // The array is read on the edge entering the response cycle.
  assign load_resp = (state_d == BUSY) && (cd_d == 4'd0);

  // Control state, in-flight slot, held response word and error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cd_q     <= '0;
      cur_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_ov_q <= 1'b0;
      err_rg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      cur_q    <= cur_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_ov_q <= err_ov_d;
      err_rg_q <= err_rg_d;
      if (load_resp) begin
        if (cur_d.oor)
          rdata_q <= NOP;
        else if (prog_we && (prog_addr == cur_d.idx))
          rdata_q <= prog_data;
        else
          rdata_q <= mem[cur_d.idx];
      end
    end
  end

  // Waiting-request storage; contents are meaningless while unoccupied.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= in_req;
  end

  // Program-port writes; the array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign bus.mem_resp_valid = (state_q == BUSY) && (cd_q == 4'd0);
  assign bus.mem_resp_data  = rdata_q;
  assign busy               = (state_q == BUSY) | ~fifo_empty;
  assign err_overflow       = err_ov_q;
  assign err_range          = err_rg_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model (request queue, absolute
// response times, word-array copy).
module tb_imem_responder;
  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam int QD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          err_clear;
  logic          busy, err_overflow, err_range;

  imem_responder_if bus ();

  imem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .err_clear    (err_clear),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_range    (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] idx;
    bit            oor;
  } mreq_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0] mm [0:(1<<AW)-1];
  mreq_t       wq[$];
  mreq_t       m_cur;
  bit          m_inflight;
  int          m_resp;
  logic [31:0] m_data;
  bit          m_ov, m_rg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_inflight = 0;
    m_data     = 32'h0;
    m_ov       = 0;
    m_rg       = 0;
  endtask

  function automatic mreq_t decode(input logic [31:0] a);
    mreq_t r;
    r.idx = a[AW+1:2];
    r.oor = (a[31:AW+2] != '0);
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc_step(input bit rq, input logic [31:0] addr, input bit we,
                          input logic [AW-1:0] wa, input logic [31:0] wd,
                          input bit clr, input bit rst);
    mreq_t in_r;
    bit    exp_valid, drop, acc;
    reset             = rst;
    bus.mem_req_valid = rq;
    bus.mem_req_addr  = addr;
    prog_we           = we;
    prog_addr         = wa;
    prog_data         = wd;
    err_clear         = clr;
    @(negedge clk);
    if (!rst) model_reset();
    exp_valid = rst && m_inflight && (cyc == m_resp);
    if (exp_valid) m_data = m_cur.oor ? NOP : mm[m_cur.idx];
    check("resp_valid", {31'h0, bus.mem_resp_valid}, {31'h0, exp_valid});
    check("resp_data", bus.mem_resp_data, m_data);
    check("busy", {31'h0, busy}, {31'h0, (m_inflight || wq.size() > 0)});
    check("err_overflow", {31'h0, err_overflow}, {31'h0, m_ov});
    check("err_range", {31'h0, err_range}, {31'h0, m_rg});
    if (rst) begin
      in_r = decode(addr);
      drop = 0;
      acc  = 0;
      if (exp_valid) begin
        if (wq.size() > 0) begin
          m_cur  = wq.pop_front();
          m_resp = cyc + LAT;
          if (rq) begin wq.push_back(in_r); acc = 1; end
        end else if (rq) begin
          m_cur = in_r; m_resp = cyc + LAT; acc = 1;
        end else begin
          m_inflight = 0;
        end
      end else if (m_inflight) begin
        if (rq) begin
          if (wq.size() == QD) drop = 1;
          else begin wq.push_back(in_r); acc = 1; end
        end
      end else if (rq) begin
        m_inflight = 1; m_cur = in_r; m_resp = cyc + LAT; acc = 1;
      end
      m_ov = (m_ov && !clr) || drop;
      m_rg = (m_rg && !clr) || (acc && in_r.oor);
      if (we) mm[wa] = wd;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_step(0, 32'h0, 0, '0, 32'h0, 0, 1);
  endtask

  task automatic rqs(input logic [31:0] a);
    cyc_step(1, a, 0, '0, 32'h0, 0, 1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cyc_step(0, 32'h0, 1, a, d, 0, 1);
  endtask

  task automatic clear_errs();
    cyc_step(0, 32'h0, 0, '0, 32'h0, 1, 1);
  endtask

  initial begin
    model_reset();
    // Reset state
    cyc_step(0, 32'h0, 0, '0, 32'h0, 0, 0);
    cyc_step(0, 32'h0, 0, '0, 32'h0, 0, 0);
    // Preload words 0..15
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      case (i)
        0: v = 32'h1;
        1: v = 32'h2;
        2: v = 32'h3;
        5: v = 32'hDEAD_BEEF;
        7: v = 32'h77;
        default: v = 32'h1000 + i;
      endcase
      wr(AW'(i), v);
    end
    // Single read, data held
    rqs(32'h14);
    idle(11);
    check("hold_deadbeef", bus.mem_resp_data, 32'hDEAD_BEEF);
    // Three back-to-back requests
    rqs(32'h0); rqs(32'h4); rqs(32'h8);
    idle(10);
    check("busy_after_burst", {31'h0, busy}, 32'h0);
    // FIFO full, pop+push on response cycle, then overflow drop
    rqs(32'h0); rqs(32'h4); rqs(32'h8); rqs(32'hC); rqs(32'h10);
    idle(1);
    check("overflow_set", {31'h0, err_overflow}, 32'h1);
    clear_errs();
    check("overflow_cleared", {31'h0, err_overflow}, 32'h0);
    idle(12);
    // Out-of-range address
    rqs(32'h0001_0000);
    idle(5);
    check("range_set", {31'h0, err_range}, 32'h1);
    clear_errs();
    idle(2);
    // Write in response cycle -> old data
    rqs(32'h1C); idle(2); wr(AW'(7), 32'hAAAA_5555);
    idle(3);
    check("race_old", bus.mem_resp_data, 32'h77);
    wr(AW'(7), 32'h77);
    // Earlier write -> new data
    rqs(32'h1C); wr(AW'(7), 32'hAAAA_5555);
    idle(5);
    check("race_new", bus.mem_resp_data, 32'hAAAA_5555);
    // Reset during an in-flight read
    rqs(32'h14);
    cyc_step(0, 32'h0, 0, '0, 32'h0, 0, 0);
    idle(10);
    rqs(32'h14);
    idle(4);
    check("array_survives_reset", bus.mem_resp_data, 32'hDEAD_BEEF);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit            rq, we, clr, rst;
      logic [31:0]   a;
      logic [AW-1:0] wa;
      rq  = ($urandom_range(0, 99) < 45);
      we  = ($urandom_range(0, 99) < 20);
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 199) != 0);
      a   = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a[31:AW+2] = 20'($urandom_range(1, 1048575));
      wa  = AW'($urandom_range(0, 15));
      if (!rst) we = 0;
      cyc_step(rq, a, we, wa, $urandom, clr, rst);
    end
    idle(12);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
